pmem_loader: RTL and testbench

- Writable program memory for the pipeline processor, plus a loader that fills it.
- Fills the memory from 4-bit nibble entries (debounced switches plus button pulse), three nibbles per 9-bit instruction.
- Serves the processor's fetch stage through an asynchronous read port.
- Holds the processor in reset until loading finishes and a run command is given.

---
 rtl/pmem_loader_pkg.sv | 29 ++
 rtl/pmem_array.sv | 39 +++
 rtl/pmem_loader.sv | 162 ++++++++++++++++
 tb/tb_pmem_loader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_loader_pkg.sv
// Shared constants for the program-memory loader and the pipeline processor:
// loader state encodings, processor opcodes and the nibble framing.
package pmem_loader_pkg;

  // Loader FSM state encodings (3-bit, legacy-compatible constants)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_NIB_HI  = 3'd1;
  localparam logic [2:0] ST_NIB_MID = 3'd2;
  localparam logic [2:0] ST_NIB_LO  = 3'd3;
  localparam logic [2:0] ST_COMMIT  = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_RUN     = 3'd6;

  // Processor opcodes (instruction bits [8:6])
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_LOADC = 3'b100;

  // A 9-bit instruction is entered as hi (bit 8 only), mid, lo nibbles
  localparam int NIBBLES_PER_WORD = 3;

  // The first nibble carries only bit 8; any higher bit set is a framing error
  function automatic logic hi_nibble_ok(input logic [3:0] nib);
    return (nib[3:1] == 3'b000);
  endfunction

endpackage

// File: rtl/pmem_array.sv
// Program memory storage: 2**AW x IW words, synchronous write, synchronous
// clear to the no-op encoding, asynchronous (combinational) read.
module pmem_array
  import pmem_loader_pkg::*;
#(
  parameter int AW = 4,
  parameter int IW = 9
) (
  input  logic          clk,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [IW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [IW-1:0] o_rd_data
);

  localparam int DEPTH = 2 ** AW;

  logic [IW-1:0] r_mem [DEPTH];

  // Clear every word to a no-op, otherwise commit one word when enabled.
  // NOTE: this memory is cleared by a loop inside the clocked block, so it
  // maps to registers rather than a RAM macro; that is intended here because
  // a freshly reset processor must fetch no-ops from every address.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {OP_NOP, {(IW - 3){1'b0}}};
      end
    end else if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Fetch port: visible in every state, including mid-load
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pmem_loader.sv
// Loader for the processor's program memory. Assembles 9-bit instructions
// from three nibble entries, commits them to consecutive addresses starting
// at 0, and keeps the processor in reset until a run command is given.
// The fixed three-nibble framing only works for IW == 9.
module pmem_loader
  import pmem_loader_pkg::*;
#(
  parameter int AW = 4,
  parameter int IW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    nib_in,
  input  logic          nib_valid,
  input  logic          start_load,
  input  logic          end_load,
  input  logic          run,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] instr,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          err,
  output logic [AW:0]   wr_count
);

  localparam logic [AW:0] LP_COUNT_MAX = {1'b1, {AW{1'b0}}};

  logic [2:0]    r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_wr_count;
  logic          r_err;
  logic [IW-1:0] r_word;

  logic [2:0]    w_state_nxt;
  logic          w_err_set;
  logic          w_lat_hi;
  logic          w_lat_mid;
  logic          w_lat_lo;
  logic          w_commit;
  logic          w_clr;

  // Next-state and nibble-latch decode; start_load outranks everything.
  // NOTE: every signal gets a default before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    w_lat_hi    = 1'b0;
    w_lat_mid   = 1'b0;
    w_lat_lo    = 1'b0;
    if (start_load) begin
      w_state_nxt = ST_NIB_HI;
    end else begin
      case (r_state)
        ST_NIB_HI: begin
          if (end_load) begin
            w_state_nxt = ST_DONE;
          end else if (nib_valid) begin
            if (hi_nibble_ok(nib_in)) begin
              w_lat_hi    = 1'b1;
              w_state_nxt = ST_NIB_MID;
            end else begin
              w_err_set = 1'b1;
            end
          end
        end
        ST_NIB_MID: begin
          if (end_load) begin
            w_state_nxt = ST_DONE;
          end else if (nib_valid) begin
            w_lat_mid   = 1'b1;
            w_state_nxt = ST_NIB_LO;
          end
        end
        ST_NIB_LO: begin
          if (end_load) begin
            w_state_nxt = ST_DONE;
          end else if (nib_valid) begin
            w_lat_lo    = 1'b1;
            w_state_nxt = ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          // The commit always completes; a last-address write or an early
          // end_load both finish the load. A nibble here has nowhere to go.
          w_state_nxt = (end_load || (r_wr_ptr == '1)) ? ST_DONE : ST_NIB_HI;
          w_err_set   = nib_valid;
        end
        ST_DONE: begin
          if (run) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_IDLE, ST_RUN: begin
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, counters, error flag and word assembly register.
  // NOTE: clocked state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_wr_count <= '0;
      r_err      <= 1'b0;
      r_word     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (start_load) begin
        r_wr_ptr   <= '0;
        r_wr_count <= '0;
        r_err      <= 1'b0;
      end else begin
        if (w_err_set) begin
          r_err <= 1'b1;
        end
        if (w_commit) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (r_wr_count != LP_COUNT_MAX) begin
            r_wr_count <= r_wr_count + 1'b1;
          end
        end
      end
      if (w_lat_hi) begin
        r_word[IW-1] <= nib_in[0];
      end
      if (w_lat_mid) begin
        r_word[7:4] <= nib_in;
      end
      if (w_lat_lo) begin
        r_word[3:0] <= nib_in;
      end
    end
  end

  // A fully assembled word is written even if start_load arrives in COMMIT
  assign w_commit = (r_state == ST_COMMIT);
  assign w_clr    = ~rst;

  pmem_array #(
    .AW (AW),
    .IW (IW)
  ) u_array (
    .clk       (clk),
    .i_clr     (w_clr),
    .i_we      (w_commit),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (r_word),
    .i_rd_addr (rd_addr),
    .o_rd_data (instr)
  );

  assign cpu_hold  = (r_state != ST_RUN);
  assign load_done = (r_state == ST_DONE) || (r_state == ST_RUN);
  assign err       = r_err;
  assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_pmem_loader.sv
// Testbench for pmem_loader: a transaction-level model (nibble queue, mode,
// memory image) is compared against the DUT on every falling edge, plus
// literal expectations at the key points of each scenario.
module tb_pmem_loader;
  import pmem_loader_pkg::*;

  localparam int AW = 4;
  localparam int IW = 9;

  logic          clk;
  logic          rst;
  logic [3:0]    nib_in;
  logic          nib_valid;
  logic          start_load;
  logic          end_load;
  logic          run;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] instr;
  logic          cpu_hold;
  logic          load_done;
  logic          err;
  logic [AW:0]   wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  pmem_loader #(.AW(AW), .IW(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .nib_in     (nib_in),
    .nib_valid  (nib_valid),
    .start_load (start_load),
    .end_load   (end_load),
    .run        (run),
    .rd_addr    (rd_addr),
    .instr      (instr),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .err        (err),
    .wr_count   (wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_LOAD, M_DONE, M_RUN} mode_t;
  mode_t      m_mode;
  logic [3:0] m_nibs[$];
  logic [8:0] m_word;
  logic [8:0] m_mem[16];
  bit         m_pending;
  int         m_ptr;
  int         m_cnt;
  bit         m_err;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_mode = M_IDLE;
      m_nibs.delete();
      m_pending = 1'b0;
      m_ptr = 0;
      m_cnt = 0;
      m_err = 1'b0;
      foreach (m_mem[i]) m_mem[i] = 9'h000;
      m_valid = 1'b1;
    end else begin
      if (m_pending) begin
        m_mem[m_ptr] = m_word;
        m_pending = 1'b0;
        if (m_cnt < 16) m_cnt++;
        if (nib_valid && !start_load) m_err = 1'b1;
        if (m_ptr == 15 || end_load) m_mode = M_DONE;
        m_ptr = (m_ptr + 1) % 16;
      end else if (m_mode == M_LOAD && !start_load) begin
        if (end_load) begin
          m_mode = M_DONE;
          m_nibs.delete();
        end else if (nib_valid) begin
          if (m_nibs.size() == 0 && nib_in[3:1] != 3'b000) begin
            m_err = 1'b1;
          end else begin
            m_nibs.push_back(nib_in);
            if (m_nibs.size() == NIBBLES_PER_WORD) begin
              m_word = {m_nibs[0][0], m_nibs[1], m_nibs[2]};
              m_nibs.delete();
              m_pending = 1'b1;
            end
          end
        end
      end else if (m_mode == M_DONE && run && !start_load) begin
        m_mode = M_RUN;
      end
      if (start_load) begin
        m_mode = M_LOAD;
        m_nibs.delete();
        m_pending = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
        m_err = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_cpu_hold", cpu_hold, (m_mode != M_RUN));
      check("cyc_load_done", load_done, (m_mode == M_DONE || m_mode == M_RUN));
      check("cyc_err", err, m_err);
      check("cyc_wr_count", wr_count, m_cnt);
      check("cyc_instr", instr, m_mem[rd_addr]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_load = 1'b1;
    tick(1);
    start_load = 1'b0;
  endtask

  task automatic do_end();
    end_load = 1'b1;
    tick(1);
    end_load = 1'b0;
  endtask

  task automatic do_run();
    run = 1'b1;
    tick(1);
    run = 1'b0;
  endtask

  task automatic nib(input logic [3:0] v);
    nib_in = v;
    nib_valid = 1'b1;
    tick(1);
    nib_valid = 1'b0;
  endtask

  // Three nibbles then the COMMIT cycle
  task automatic word(input logic [8:0] w);
    nib({3'b000, w[8]});
    nib(w[7:4]);
    nib(w[3:0]);
    tick(1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [8:0] exp);
    rd_addr = a;
    tick(1);
    check(name, instr, exp);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [8:0] w;
    logic [3:0] a;
    rst = 1'b0; nib_in = '0; nib_valid = 1'b0; start_load = 1'b0;
    end_load = 1'b0; run = 1'b0; rd_addr = '0;

    // Reset state and cleared memory
    do_reset();
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_load_done", load_done, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_err", err, 0);
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      read_check("rst_mem", a, 9'h000);
    end

    // Single word 1,4,5 -> 0x145, visible the cycle after COMMIT
    rd_addr = 4'd0;
    do_start();
    nib(4'h1); nib(4'h4); nib(4'h5);
    check("commit_old_read", instr, 9'h000);
    tick(1);
    check("first_word", instr, 9'h145);
    check("first_count", wr_count, 1);

    // Full 16-word load, run, read back
    do_start();
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      word({3'b010, a[1:0], a});
    end
    check("full_load_done", load_done, 1);
    check("full_count", wr_count, 16);
    check("full_hold_before_run", cpu_hold, 1);
    do_run();
    check("run_cpu_hold", cpu_hold, 0);
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      w = {3'b010, a[1:0], a};
      read_check("full_readback", a, w);
    end

    // Framing error on first nibble, then a valid word; err is sticky
    rd_addr = 4'd0;
    do_start();
    check("restart_hold", cpu_hold, 1);
    nib(4'h3);
    check("frame_err", err, 1);
    check("frame_count", wr_count, 0);
    check("frame_no_write", instr, 9'h080);
    word(9'h0FF);
    check("frame_word", instr, 9'h0FF);
    check("frame_err_sticky", err, 1);
    do_start();
    check("frame_err_clear", err, 0);

    // Two words, a partial word, then end_load
    do_reset();
    do_start();
    word(9'h1A5);
    word(9'h033);
    nib(4'h1);
    do_end();
    check("early_done", load_done, 1);
    check("early_count", wr_count, 2);
    check("early_err", err, 0);
    read_check("early_mem2", 4'd2, 9'h000);
    read_check("early_mem0", 4'd0, 9'h1A5);
    read_check("early_mem1", 4'd1, 9'h033);

    // From RUN: start_load with a simultaneous nibble drops the nibble
    do_run();
    check("run2_hold", cpu_hold, 0);
    start_load = 1'b1; nib_valid = 1'b1; nib_in = 4'h1;
    tick(1);
    start_load = 1'b0; nib_valid = 1'b0;
    check("start_nib_hold", cpu_hold, 1);
    check("start_nib_err", err, 0);
    word(9'h012);
    read_check("start_nib_word", 4'd0, 9'h012);

    // end_load during COMMIT still completes the write
    nib(4'h1); nib(4'h2); nib(4'h3);
    do_end();
    check("commit_end_done", load_done, 1);
    check("commit_end_count", wr_count, 2);
    read_check("commit_end_word", 4'd1, 9'h123);

    // Nibble arriving during COMMIT is dropped and flags an overrun
    rd_addr = 4'd0;
    do_start();
    nib(4'h0); nib(4'h1); nib(4'h1);
    nib(4'h5);
    check("overrun_err", err, 1);
    check("overrun_word", instr, 9'h011);
    check("overrun_count", wr_count, 1);

    // Reset mid-word aborts the load and clears memory
    nib(4'h1); nib(4'h7);
    do_reset();
    check("midrst_hold", cpu_hold, 1);
    check("midrst_done", load_done, 0);
    check("midrst_count", wr_count, 0);
    check("midrst_err", err, 0);
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      read_check("midrst_mem", a, 9'h000);
    end
    nib(4'h2); nib(4'h2); nib(4'h2);
    tick(1);
    check("idle_ignore_count", wr_count, 0);
    check("idle_ignore_done", load_done, 0);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
